// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions for the write and read pointer controllers.
// Contents:
//   DEF_ALEN   - default RAM address width
//   DEF_DROP_W - default dropped-write counter width
//   ptr_diff() - pointer subtraction modulo 2**pw (pw = pointer width incl. wrap bit)
package fifo_pkg;

    localparam int unsigned DEF_ALEN   = 8;
    localparam int unsigned DEF_DROP_W = 8;

    // Callers zero-extend the pointers to 32 bits and truncate the result back to pw bits.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned pw);
        logic [31:0] mask;
        mask = (pw >= 32) ? '1 : ((32'd1 << pw) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/fifo_level.sv
// Fill level between two FIFO pointers that carry a wrap bit.
// Ports:
//   ptr_a_i  in  ALEN+1  leading pointer (write side)
//   ptr_b_i  in  ALEN+1  trailing pointer (read side)
//   level_o  out ALEN+1  (ptr_a_i - ptr_b_i) mod 2**(ALEN+1), range 0..2**ALEN
module fifo_level
    import fifo_pkg::*;
#(
    parameter int unsigned ALEN = DEF_ALEN
) (
    input  logic [ALEN:0] ptr_a_i,
    input  logic [ALEN:0] ptr_b_i,
    output logic [ALEN:0] level_o
);

    localparam int unsigned PW = ALEN + 1;

    assign level_o = PW'(ptr_diff(32'(ptr_a_i), 32'(ptr_b_i), PW));

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer and flag controller for the synchronous UART FIFO.
// Gates write requests into the RAM write strobe, advances the wrap-bit write pointer and keeps
// a registered full flag, a sticky overflow flag and a saturating dropped-write counter.
// Optional feature macro: WR_PTR_LEVEL_EN adds o_wlevel / o_walmost_full and the AFULL_LVL
// parameter.
// Ports:
//   clk             in   clock, rising edge
//   rstn            in   asynchronous active-low reset
//   i_wen           in   write request
//   i_rptr          in   read pointer (ALEN+1), same clock domain
//   i_ovf_clr       in   clears overflow flag and drop counter
//   o_ram_wen       out  RAM write strobe (combinational)
//   o_waddr         out  RAM write address
//   o_wptr          out  write pointer incl. wrap bit
//   o_wfull         out  registered full flag
//   o_woverflow     out  sticky reject flag
//   o_wdrop_cnt     out  saturating count of rejected writes
//   o_wlevel        out  fill level (WR_PTR_LEVEL_EN)
//   o_walmost_full  out  registered level >= AFULL_LVL (WR_PTR_LEVEL_EN)
module wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ALEN   = DEF_ALEN,
    parameter int unsigned INCR   = 1,
    parameter int unsigned DROP_W = DEF_DROP_W
`ifdef WR_PTR_LEVEL_EN
    ,
    parameter int unsigned AFULL_LVL = (1 << ALEN) - 2
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wen,
    input  logic [ALEN:0]     i_rptr,
    input  logic              i_ovf_clr,
    output logic              o_ram_wen,
    output logic [ALEN-1:0]   o_waddr,
    output logic [ALEN:0]     o_wptr,
    output logic              o_wfull,
    output logic              o_woverflow,
    output logic [DROP_W-1:0] o_wdrop_cnt
`ifdef WR_PTR_LEVEL_EN
    ,
    output logic [ALEN:0]     o_wlevel,
    output logic              o_walmost_full
`endif
);

    localparam int unsigned PW    = ALEN + 1;
    localparam int unsigned DEPTH = 1 << ALEN;

    logic [ALEN:0]     wptr_q, wptr_d;
    logic [ALEN:0]     level_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              accept, reject;

    assign accept = i_wen & ~full_q;
    assign reject = i_wen & full_q;

    always_comb begin
        wptr_d = wptr_q;
        if (accept) begin
            wptr_d = wptr_q + PW'(INCR);
        end
    end

    // Level after this edge's write against the current read pointer; a read landing this
    // cycle is only seen next cycle, so full clears one cycle late (never early).
    fifo_level #(
        .ALEN (ALEN)
    ) u_level_next (
        .ptr_a_i (wptr_d),
        .ptr_b_i (i_rptr),
        .level_o (level_d)
    );

    // Full when less than one INCR step of space remains.
    assign full_d = (32'(level_d) + INCR) > DEPTH;

    // Clear wins over a simultaneous reject, which is then not counted.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (i_ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (reject) begin
            ovf_d = 1'b1;
            if (!(&drop_q)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign o_ram_wen   = accept;
    assign o_waddr     = wptr_q[ALEN-1:0];
    assign o_wptr      = wptr_q;
    assign o_wfull     = full_q;
    assign o_woverflow = ovf_q;
    assign o_wdrop_cnt = drop_q;

`ifdef WR_PTR_LEVEL_EN
    logic afull_q;

    fifo_level #(
        .ALEN (ALEN)
    ) u_level_out (
        .ptr_a_i (wptr_q),
        .ptr_b_i (i_rptr),
        .level_o (o_wlevel)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= 32'(level_d) >= AFULL_LVL;
        end
    end

    assign o_walmost_full = afull_q;
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
module tb_wr_ptr_ctrl;

    localparam int ALEN     = 3;
    localparam int DEPTH    = 8;
    localparam int PMOD     = 16;
    localparam int DROP_MAX = 3;
    localparam int AFULL    = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wen = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] rptr = 4'd0;

    logic       ram_wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       woverflow;
    logic [1:0] wdrop_cnt;
`ifdef WR_PTR_LEVEL_EN
    logic [3:0] wlevel;
    logic       walmost_full;
`endif

    wr_ptr_ctrl #(
        .ALEN   (ALEN),
        .INCR   (1),
        .DROP_W (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wen       (wen),
        .i_rptr      (rptr),
        .i_ovf_clr   (ovf_clr),
        .o_ram_wen   (ram_wen),
        .o_waddr     (waddr),
        .o_wptr      (wptr),
        .o_wfull     (wfull),
        .o_woverflow (woverflow),
        .o_wdrop_cnt (wdrop_cnt)
`ifdef WR_PTR_LEVEL_EN
        ,
        .o_wlevel       (wlevel),
        .o_walmost_full (walmost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ram_wen;
        int waddr;
        int wptr;
        bit full;
        bit ovf;
        int drop;
        int level;
        bit afull;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference state: pointers as plain integers, FIFO occupancy from their difference.
    int m_wptr = 0;
    int m_rptr = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    int m_drop = 0;
    bit m_afull = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int occ(input int w, input int r);
        return (w - r + PMOD) % PMOD;
    endfunction

    // Called at posedge+1: drive inputs, queue expected outputs, advance the model over the edge.
    task automatic cycle(input bit w, input int r, input bit c);
        exp_t e;
        bit   acc, rej;
        int   lvl;
        wen = w;
        rptr = 4'(r);
        ovf_clr = c;
        m_rptr = r;
        e.ram_wen = w && !m_full;
        e.waddr = m_wptr % DEPTH;
        e.wptr = m_wptr;
        e.full = m_full;
        e.ovf = m_ovf;
        e.drop = m_drop;
        e.level = occ(m_wptr, r);
        e.afull = m_afull;
        q.push_back(e);
        acc = w && !m_full;
        rej = w && m_full;
        @(posedge clk);
        #1;
        if (acc) m_wptr = (m_wptr + 1) % PMOD;
        lvl = occ(m_wptr, r);
        m_full = (DEPTH - lvl) < 1;
        m_afull = lvl >= AFULL;
        if (c) begin
            m_ovf = 0;
            m_drop = 0;
        end else if (rej) begin
            m_ovf = 1;
            if (m_drop < DROP_MAX) m_drop = m_drop + 1;
        end
    endtask

    // Called at posedge+1: reset asserts between edges so the following negedge proves it is async.
    task automatic do_reset();
        exp_t e;
        rstn = 1'b0;
        wen = 1'b0;
        ovf_clr = 1'b0;
        rptr = 4'd0;
        m_wptr = 0;
        m_rptr = 0;
        m_full = 0;
        m_ovf = 0;
        m_drop = 0;
        m_afull = 0;
        e = '{ram_wen: 0, waddr: 0, wptr: 0, full: 0, ovf: 0, drop: 0, level: 0, afull: 0};
        q.push_back(e);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ram_wen", int'(ram_wen), int'(e.ram_wen));
                check("waddr", int'(waddr), e.waddr);
                check("wptr", int'(wptr), e.wptr);
                check("wfull", int'(wfull), int'(e.full));
                check("woverflow", int'(woverflow), int'(e.ovf));
                check("wdrop_cnt", int'(wdrop_cnt), e.drop);
`ifdef WR_PTR_LEVEL_EN
                check("wlevel", int'(wlevel), e.level);
                check("walmost_full", int'(walmost_full), int'(e.afull));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int r;
        @(posedge clk);
        #1;
        do_reset();

        // Fill: addresses 0..7, then full with wrap bit set.
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        check("wptr_after_fill", int'(wptr), 8);
        check("full_after_fill", int'(wfull), 1);

        // Three rejects, then clear.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        check("drop_after_3", int'(wdrop_cnt), 3);
        check("ovf_after_3", int'(woverflow), 1);
        cycle(0, 0, 1);
        check("drop_after_clr", int'(wdrop_cnt), 0);
        check("ovf_after_clr", int'(woverflow), 0);

        // Read frees one slot; full drops a cycle later; next write refills.
        cycle(0, 1, 0);
        check("full_clears_late", int'(wfull), 0);
        cycle(1, 1, 0);
        check("wptr_after_refill", int'(wptr), 9);
        check("full_after_refill", int'(wfull), 1);

        // Write + read while full: rejected, full clears next cycle.
        cycle(1, 2, 0);
        check("full_after_rw", int'(wfull), 0);
        check("drop_after_rw", int'(wdrop_cnt), 1);
        cycle(1, 2, 0);

        // Saturation: five more rejects, clear coinciding with a reject.
        for (int i = 0; i < 5; i++) cycle(1, 2, 0);
        check("drop_saturated", int'(wdrop_cnt), 3);
        cycle(1, 2, 1);
        check("clr_beats_reject", int'(wdrop_cnt), 0);

        // Six writes from empty, then reset mid-burst.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
`ifdef WR_PTR_LEVEL_EN
        check("level_after_6", int'(wlevel), 6);
        check("afull_after_6", int'(walmost_full), 1);
`endif
        check("wptr_after_6", int'(wptr), 6);
        cycle(1, 0, 0);
        do_reset();

        // Random traffic with a well-behaved read side.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                r = m_rptr;
                if (occ(m_wptr, m_rptr) > 0 && $urandom_range(2) == 0) r = (m_rptr + 1) % PMOD;
                cycle(($urandom_range(2) != 0), r, ($urandom_range(15) == 0));
            end
        end
        cycle(0, m_rptr, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
